// File: rtl/ins_fetch_unit_pkg.sv
// ins_fetch_unit_pkg: shared fetch widths, HALT opcode and fetch buffer entry type
package ins_fetch_unit_pkg;

    localparam int ADDR_W = 8;
    localparam int INS_W  = 16;
    localparam logic [INS_W-1:0] HALT_OPCODE = 16'hFFFF;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  ins;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INS_W-1:0] ins);
        return ins == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/ins_fetch_unit_if.sv
// ins_fetch_unit_if: instruction memory read port plus decoder valid/ready handshake
interface ins_fetch_unit_if;
    import ins_fetch_unit_pkg::*;

    logic [ADDR_W-1:0] ins_mem_add;
    logic [INS_W-1:0]  mem_out_ins;
    logic              ins_valid;
    logic              ins_ready;
    logic [INS_W-1:0]  ins_data;
    logic [ADDR_W-1:0] ins_pc;

    modport master (
        output ins_mem_add, ins_valid, ins_data, ins_pc,
        input  mem_out_ins, ins_ready
    );

    modport slave (
        input  ins_mem_add, ins_valid, ins_data, ins_pc,
        output mem_out_ins, ins_ready
    );

endinterface

// File: rtl/ins_fetch_unit_buf.sv
// ins_fetch_unit_buf: DEPTH-entry shifting FIFO of fetch entries; head is always entry 0 (a register)
module ins_fetch_unit_buf
    import ins_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic [CW-1:0] count
);

    fetch_entry_t  ent   [DEPTH];
    fetch_entry_t  ent_n [DEPTH];
    logic [CW-1:0] cnt_pop;
    logic [CW-1:0] cnt_n;

    // pop shifts everything toward the head, push lands just behind the surviving entries
    always_comb begin
        cnt_pop = count - CW'(pop);
        ent_n   = ent;
        if (pop)
            for (int i = 0; i < DEPTH - 1; i++) ent_n[i] = ent[i + 1];
        for (int i = 0; i < DEPTH; i++)
            if (push && cnt_pop == CW'(i)) ent_n[i] = din;
        cnt_n = cnt_pop + CW'(push);
    end

    // storage and occupancy; flush only empties, stale entry contents are never presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ent   <= '{default: '0};
        end else begin
            count <= flush ? '0 : cnt_n;
            ent   <= ent_n;
        end
    end

    assign head = ent[0];
    assign full = count == CW'(DEPTH);

endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: PC, credit-based issue to synchronous imem, capture into fetch buffer, redirect/halt.
// Optional feature: define FETCH_HALT_EN to stop fetching after a HALT opcode is captured.
module ins_fetch_unit
    import ins_fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    ins_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              halted_q;
    logic              issue;
    logic              push;
    logic              pop;
    logic              full;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    fetch_entry_t      head;

    // occupancy counts the in-flight return as already owning a slot, so nothing captured is dropped
    assign pop   = bus.ins_valid & bus.ins_ready;
    assign push  = inflight & ~redirect & ~halted_q;
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue = fetch_en & ~halted_q & ~redirect & ~(full & ~pop) & (occ < (CW + 1)'(DEPTH));

    assign bus.ins_mem_add = pc_q;
    assign bus.ins_valid   = count != '0;
    assign bus.ins_data    = head.ins;
    assign bus.ins_pc      = head.pc;
    assign halted          = halted_q;

    // PC advance, redirect and in-flight tracking; memory answers the cycle after issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) req_pc <= pc_q;
            if (redirect) pc_q <= redirect_pc;
            else if (issue) pc_q <= pc_q + 1'b1;
        end
    end

`ifdef FETCH_HALT_EN
    // a captured HALT stops issue; anything arriving behind it is dropped via push gating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else halted_q <= redirect ? 1'b0 : (halted_q | (push & is_halt(bus.mem_out_ins)));
    end
`else
    assign halted_q = 1'b0;
`endif

    ins_fetch_unit_buf #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({req_pc, bus.mem_out_ins}),
        .head  (head),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb_ins_fetch_unit: scoreboard bench; expected stream is sequential PCs from each (re)start point
module tb_ins_fetch_unit;
    import ins_fetch_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_en = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halted;

    ins_fetch_unit_if bus();

    ins_fetch_unit #(.DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) bus.mem_out_ins <= mem[bus.ins_mem_add];

    logic [23:0] sb [$];
    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void restart(input logic [7:0] pc, input int n);
        logic [7:0] p;
        sb.delete();
        p = pc;
        for (int i = 0; i < n; i++) begin
            sb.push_back({p, mem[p]});
            p = p + 8'd1;
        end
    endfunction

    // monitor: every transfer must be the next expected {pc, ins}; stalled outputs must hold
    initial begin
        logic        stall;
        logic        redir_prev;
        logic [23:0] held;
        logic [23:0] e;
        stall = 1'b0;
        redir_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                redir_prev = 1'b0;
            end else begin
                if (stall && !redir_prev)
                    chk(bus.ins_valid && {bus.ins_pc, bus.ins_data} == held, "stall_hold",
                        {7'd0, bus.ins_valid, bus.ins_pc, bus.ins_data}, {8'h01, held});
                if (bus.ins_valid && bus.ins_ready) begin
                    xfers++;
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_xfer", {8'h00, bus.ins_pc, bus.ins_data}, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        chk({bus.ins_pc, bus.ins_data} == e, "xfer", {8'h00, bus.ins_pc, bus.ins_data}, {8'h00, e});
                    end
                end
                stall = bus.ins_valid && !bus.ins_ready;
                held = {bus.ins_pc, bus.ins_data};
                redir_prev = redirect;
            end
        end
    end

    // called at posedge+1: pulse redirect for one cycle, restart the expected stream, optionally check latency
    task automatic do_redirect(input logic [7:0] pc, input int n, input bit tim);
        redirect = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        restart(pc, n);
        #1 redirect = 1'b0;
        if (tim) begin
            @(negedge clk); chk(!bus.ins_valid, "redir_gap1", {31'd0, bus.ins_valid}, 32'd0);
            @(negedge clk); chk(!bus.ins_valid, "redir_gap2", {31'd0, bus.ins_valid}, 32'd0);
            @(negedge clk); chk(bus.ins_valid && bus.ins_pc == pc, "redir_first",
                                {23'd0, bus.ins_valid, bus.ins_pc}, {23'd1, pc});
        end
    endtask

    // called at posedge+1: async reset mid-cycle, then restart streaming from RESET_PC
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk(!bus.ins_valid, "rst_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk(bus.ins_mem_add == 8'h00, "rst_pc", {24'd0, bus.ins_mem_add}, 32'd0);
        chk(!halted, "rst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        restart(8'h00, 600);
        fetch_en = 1'b1;
        bus.ins_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(bus.ins_valid == (k >= 2), "rst_restart_valid", {31'd0, bus.ins_valid}, {31'd0, k >= 2});
        end
        chk(bus.ins_pc == 8'h00, "rst_restart_pc", {24'd0, bus.ins_pc}, 32'd0);
    endtask

    initial begin
        logic [7:0] a0;
        logic [7:0] exp_add;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        bus.ins_ready = 1'b1;
        fetch_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(!bus.ins_valid, "reset_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk(bus.ins_data == 16'h0, "reset_data", {16'd0, bus.ins_data}, 32'd0);
        chk(bus.ins_pc == 8'h00, "reset_ins_pc", {24'd0, bus.ins_pc}, 32'd0);
        chk(bus.ins_mem_add == 8'h00, "reset_mem_add", {24'd0, bus.ins_mem_add}, 32'd0);
        chk(!halted, "reset_halted", {31'd0, halted}, 32'd0);
        restart(8'h00, 600);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk(bus.ins_valid == (k >= 2), "start_valid", {31'd0, bus.ins_valid}, {31'd0, k >= 2});
        end

        // stall for 5 cycles: two entries held (head, head+1), next address head+2 and frozen
        @(posedge clk);
        #1 bus.ins_ready = 1'b0;
        repeat (2) @(negedge clk);
        a0 = bus.ins_mem_add;
        repeat (3) @(negedge clk);
        exp_add = bus.ins_pc + 8'd2;
        chk(bus.ins_mem_add == a0, "stall_pc_frozen", {24'd0, bus.ins_mem_add}, {24'd0, a0});
        chk(bus.ins_valid && bus.ins_mem_add == exp_add, "stall_credit",
            {24'd0, bus.ins_mem_add}, {24'd0, exp_add});
        @(posedge clk);
        #1 bus.ins_ready = 1'b1;
        repeat (10) @(posedge clk);

        #1 do_redirect(8'h40, 600, 1'b1);
        repeat (20) @(posedge clk);
        #1 do_redirect(8'hFE, 600, 1'b1);
        repeat (10) @(posedge clk);

        #1 do_reset();
        repeat (10) @(posedge clk);

`ifdef FETCH_HALT_EN
        mem[5] = 16'hFFFF;
        #1 do_redirect(8'h00, 6, 1'b1);
        repeat (20) @(negedge clk);
        chk(halted, "halt_set", {31'd0, halted}, 32'd1);
        chk(!bus.ins_valid, "halt_idle", {31'd0, bus.ins_valid}, 32'd0);
        mem[5] = 16'h1005;
        @(posedge clk);
        #1 do_redirect(8'h00, 600, 1'b1);
        chk(!halted, "halt_cleared", {31'd0, halted}, 32'd0);
        repeat (10) @(posedge clk);
`endif

        // randomized traffic with occasional redirects and one reset
        for (int it = 0; it < 1500; it++) begin
            @(posedge clk);
            #1;
            bus.ins_ready = ($urandom % 4) != 0;
            fetch_en = ($urandom % 8) != 0;
            if (it == 700) do_reset();
            else if (($urandom % 50) == 0) do_redirect(8'($urandom), 600, fetch_en);
        end

        @(posedge clk);
        #1;
        bus.ins_ready = 1'b1;
        fetch_en = 1'b1;
        repeat (20) @(negedge clk);
        chk(!halted, "final_halted", {31'd0, halted}, 32'd0);
        chk(xfers > 500, "xfer_count", xfers, 32'd500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
